// File: rtl/GEMM_pkg.sv
`default_nettype none
// ============================================================================
// Module      : GEMM_pkg
// Description : Types shared by the GEMM array and its output collector.
//               command_t          - command driven to the systolic array
//               collector_state_t  - output collector FSM state
// Revision    : 1.0 - initial release
// ============================================================================
package GEMM_pkg;

    typedef enum logic [1:0] {
        CMD_NONE          = 2'd0,
        CMD_WRITE_WEIGHTS = 2'd1,
        CMD_STREAM        = 2'd2
    } command_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } collector_state_t;

endpackage
`default_nettype wire

// File: rtl/gemm_output_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : gemm_output_collector_if
// Description : Bus bundle between the GEMM array / job controller / row
//               consumer (master) and the output collector (slave).
//   start, job_rows          job control into the collector
//   cmd, activation_outputs,
//   output_valid             result rows streamed by the array
//   out_row_*                valid/ready row stream to the consumer
//   busy, done, overflow     job status
// Revision    : 1.0 - initial release
// ============================================================================
interface gemm_output_collector_if #(
    parameter int SA_SIZE                = 4,
    parameter int WEIGHT_ACTIVATION_SIZE = 8,
    parameter int MAX_ROWS               = 16
);
    import GEMM_pkg::*;

    logic                                              start;
    logic [$clog2(MAX_ROWS+1)-1:0]                     job_rows;
    command_t                                          cmd;
    logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]    activation_outputs;
    logic                                              output_valid;
    logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]    out_row_data;
    logic [$clog2(MAX_ROWS)-1:0]                       out_row_idx;
    logic                                              out_row_valid;
    logic                                              out_row_ready;
    logic                                              busy;
    logic                                              done;
    logic                                              overflow;

    modport master (
        output start, job_rows, cmd, activation_outputs, output_valid,
               out_row_ready,
        input  out_row_data, out_row_idx, out_row_valid, busy, done, overflow
    );

    modport slave (
        input  start, job_rows, cmd, activation_outputs, output_valid,
               out_row_ready,
        output out_row_data, out_row_idx, out_row_valid, busy, done, overflow
    );

endinterface
`default_nettype wire

// File: rtl/gemm_row_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gemm_row_fifo
// Description : Small synchronous FIFO for tagged result rows. The head entry
//               is read straight from the storage registers at the read
//               pointer, so head_o changes only on a clock edge.
//   clk, reset     clock, asynchronous active-high reset
//   clear_i        synchronous flush (pointers back to zero)
//   push_i         push request; accepted when not full, or full with a pop
//   push_data_i    entry to push
//   pop_i          pop request; ignored when empty
//   head_o         oldest entry
//   full_o/empty_o occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module gemm_row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4     // power of two, >= 2
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             clear_i,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] push_data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] head_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    // One extra pointer bit tells full (MSBs differ) from empty (equal).
    logic [PTR_W:0]                wr_ptr_q;
    logic [PTR_W:0]                rd_ptr_q;
    logic [DEPTH-1:0][WIDTH-1:0]   mem_q;
    logic                          do_pop;
    logic                          do_push;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign do_push = push_i && (!full_o || do_pop);

    assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
                wr_ptr_q                   <= wr_ptr_q + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gemm_output_collector.sv
`default_nettype none
// ============================================================================
// Module      : gemm_output_collector
// Description : Captures result rows streamed by the GEMM array (which cannot
//               be stalled), tags each with its row index, buffers them and
//               hands them to a consumer over valid/ready. Counts rows per
//               job, flags dropped rows and pulses done when the job is fully
//               delivered.
//   clk, reset   clock, asynchronous active-high reset
//   bus          gemm_output_collector_if slave port (job control, array
//                rows in, tagged rows out, busy/done/overflow status)
// Revision    : 1.0 - initial release
// ============================================================================
module gemm_output_collector
    import GEMM_pkg::*;
#(
    parameter int SA_SIZE                = 4,
    parameter int WEIGHT_ACTIVATION_SIZE = 8,
    parameter int MAX_ROWS               = 16,
    parameter int FIFO_DEPTH             = 4
) (
    input  wire logic               clk,
    input  wire logic               reset,
    gemm_output_collector_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_ROWS + 1);
    localparam int IDX_W = $clog2(MAX_ROWS);
    localparam int ROW_W = SA_SIZE * WEIGHT_ACTIVATION_SIZE;
    localparam int ENT_W = IDX_W + ROW_W;

    collector_state_t  state_q, state_d;
    logic [CNT_W-1:0]  job_rows_q, job_rows_d;
    logic [CNT_W-1:0]  cap_cnt_q, cap_cnt_d;
    logic              overflow_q, overflow_d;

    logic              start_ok;
    logic              capture;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ENT_W-1:0]  push_entry;
    logic [ENT_W-1:0]  head_entry;

    assign start_ok = (state_q == S_IDLE) && bus.start;
    assign capture  = (state_q == S_COLLECT) && bus.output_valid &&
                      (bus.cmd == CMD_STREAM);
    assign pop      = bus.out_row_valid && bus.out_row_ready;
    assign drop     = capture && fifo_full && !pop;

    // Index is the capture count, so dropped rows still consume an index.
    assign push_entry = {cap_cnt_q[IDX_W-1:0], bus.activation_outputs};

    gemm_row_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (start_ok),
        .push_i      (capture),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign bus.out_row_valid = !fifo_empty;
    assign bus.out_row_idx   = head_entry[ENT_W-1 -: IDX_W];
    assign bus.out_row_data  = head_entry[ROW_W-1:0];
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = (state_q == S_DONE);
    assign bus.overflow      = overflow_q;

    always_comb begin
        state_d    = state_q;
        job_rows_d = job_rows_q;
        cap_cnt_d  = cap_cnt_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    job_rows_d = bus.job_rows;
                    cap_cnt_d  = '0;
                    overflow_d = 1'b0;
                    state_d    = (bus.job_rows == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (capture) begin
                    cap_cnt_d = cap_cnt_q + CNT_W'(1);
                    if (drop) begin
                        overflow_d = 1'b1;
                    end
                    if (cap_cnt_d == job_rows_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            job_rows_q <= '0;
            cap_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            job_rows_q <= job_rows_d;
            cap_cnt_q  <= cap_cnt_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
`default_nettype wire
